// File: rtl/fetch_decode_ctrl_if.sv
// Sequencer-side bus of the lab processor: PC/ROM inputs, register-file,
// ALU and data-memory strobes, and status flags.
interface fetch_decode_ctrl_if #(
    parameter int PC_W    = 3,
    parameter int INSTR_W = 12
) ();
    logic               start;
    logic [PC_W-1:0]    pc_addr;
    logic [INSTR_W-1:0] instr_in;
    logic               pc_ld;
    logic [INSTR_W-1:0] ir_q;
    logic [2:0]         rf_raddr_a;
    logic [2:0]         rf_raddr_b;
    logic [2:0]         rf_waddr;
    logic               rf_we;
    logic               rf_wsel;
    logic               alu_op;
    logic [3:0]         dm_addr;
    logic               dm_we;
    logic               busy;
    logic               halted;
    logic               illegal;

    modport master (
        input  start, pc_addr, instr_in,
        output pc_ld, ir_q, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel,
               alu_op, dm_addr, dm_we, busy, halted, illegal
    );

    modport slave (
        output start, pc_addr, instr_in,
        input  pc_ld, ir_q, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel,
               alu_op, dm_addr, dm_we, busy, halted, illegal
    );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 3-bit-PC lab processor.
// Optional single-step mode (step port, PAUSE state) under `FDC_STEP_MODE_EN.
module fetch_decode_ctrl #(
    parameter int PC_W         = 3,
    parameter int INSTR_W      = 12,
    parameter int MEM_LAT      = 1,
    parameter int HALT_ON_WRAP = 0
) (
    input  logic clk,
    input  logic reset,
`ifdef FDC_STEP_MODE_EN
    input  logic step,
`endif
    fetch_decode_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
`ifdef FDC_STEP_MODE_EN
        , S_PAUSE
`endif
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [PC_W-1:0] PC_LAST  = '1;
    localparam logic [1:0]      LAT_LAST = 2'(MEM_LAT - 1);

    state_t             state, state_nxt, resume;
    logic [INSTR_W-1:0] ir_q;
    logic [PC_W-1:0]    pc_cur;
    logic [1:0]         lat_cnt;
    logic               illegal_q;

    logic [2:0] op, fld_r, fld_a, fld_b;
    logic [3:0] fld_addr;
    logic       op_illegal;

    assign op         = ir_q[11:9];
    assign fld_r      = ir_q[8:6];
    assign fld_a      = ir_q[5:3];
    assign fld_b      = ir_q[2:0];
    assign fld_addr   = ir_q[3:0];
    assign op_illegal = (op == 3'b101) || (op == 3'b110);

    // Where a completed instruction goes: halt at the top address when
    // wrap-halting is enabled, otherwise on to the next fetch (or pause).
    always_comb begin
        resume = S_FETCH;
`ifdef FDC_STEP_MODE_EN
        resume = S_PAUSE;
`endif
        if (HALT_ON_WRAP != 0 && pc_cur == PC_LAST) begin
            resume = S_HALT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_NOP:                  state_nxt = resume;
                    OP_LOAD:                 state_nxt = S_MEM;
                    OP_STORE, OP_ADD, OP_SUB: state_nxt = S_EXEC;
                    default:                 state_nxt = S_HALT;
                endcase
            end
            S_EXEC:   state_nxt = resume;
            S_MEM:    if (lat_cnt == LAT_LAST) state_nxt = S_WB;
            S_WB:     state_nxt = resume;
            S_HALT:   state_nxt = S_HALT;
`ifdef FDC_STEP_MODE_EN
            S_PAUSE:  if (step) state_nxt = S_FETCH;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q      <= '0;
            pc_cur    <= '0;
            lat_cnt   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (state == S_FETCH) begin
                ir_q   <= bus.instr_in;
                pc_cur <= bus.pc_addr;
            end
            if (state == S_MEM) begin
                lat_cnt <= (lat_cnt == LAT_LAST) ? 2'd0 : lat_cnt + 2'd1;
            end
            if (state == S_DECODE && op_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from state and the held instruction.
    always_comb begin
        bus.pc_ld      = 1'b0;
        bus.rf_raddr_a = 3'd0;
        bus.rf_raddr_b = 3'd0;
        bus.rf_waddr   = 3'd0;
        bus.rf_we      = 1'b0;
        bus.rf_wsel    = 1'b0;
        bus.alu_op     = 1'b0;
        bus.dm_addr    = 4'd0;
        bus.dm_we      = 1'b0;
        bus.busy       = 1'b0;
        case (state)
            S_FETCH:  bus.busy = 1'b1;
            S_DECODE: begin
                bus.busy  = 1'b1;
                bus.pc_ld = 1'b1;
            end
            S_EXEC: begin
                bus.busy = 1'b1;
                if (op == OP_STORE) begin
                    bus.rf_raddr_a = fld_r;
                    bus.dm_addr    = fld_addr;
                    bus.dm_we      = 1'b1;
                end else begin
                    bus.rf_raddr_a = fld_a;
                    bus.rf_raddr_b = fld_b;
                    bus.alu_op     = (op == OP_SUB);
                    bus.rf_waddr   = fld_r;
                    bus.rf_we      = 1'b1;
                end
            end
            S_MEM: begin
                bus.busy    = 1'b1;
                bus.dm_addr = fld_addr;
            end
            S_WB: begin
                bus.busy     = 1'b1;
                bus.dm_addr  = fld_addr;
                bus.rf_waddr = fld_r;
                bus.rf_wsel  = 1'b1;
                bus.rf_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ir_q    = ir_q;
    assign bus.halted  = (state == S_HALT);
    assign bus.illegal = illegal_q;

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer that consumes the program counter: reads the current PC value, captures the instruction word from instruction memory, and issues the one-cycle PC load (increment) strobe.
- Sequences register-file, ALU and data-memory control strobes for each instruction.
- Sits between the 3-bit PC, instruction ROM, register file, ALU and data RAM of the lab processor.

Parameters:
- PC_W, 3, PC width; program wraps at 2**PC_W-1.
- INSTR_W, 12, instruction width; fixed field layout below requires 12.
- MEM_LAT, 1, data-memory read latency in cycles (legal 1..3).
- HALT_ON_WRAP, 0, 1 = halt after executing the instruction at address 2**PC_W-1 instead of wrapping.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  level; begins execution from IDLE.
- pc_addr  input  PC_W  current PC value.
- instr_in  input  INSTR_W  instruction memory data at pc_addr (combinational ROM).
- pc_ld  output  1  PC increment strobe.
- ir_q  output  INSTR_W  instruction register.
- rf_raddr_a / rf_raddr_b  output  3 each  register-file read addresses.
- rf_waddr  output  3  register-file write address.
- rf_we  output  1  register-file write enable.
- rf_wsel  output  1  write-data select: 0 = ALU, 1 = data memory.
- alu_op  output  1  0 = add, 1 = sub.
- dm_addr  output  4  data-memory address.
- dm_we  output  1  data-memory write enable.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.
- illegal  output  1  sticky; set on undefined opcode.

Behaviour:
- Instruction fields: [11:9] opcode, [8:6] r, [5:3] a, [2:0] b, [3:0] mem addr.
- Opcodes:
  - 000 NOP.
  - 001 LOAD r <- dm[addr].
  - 010 STORE dm[addr] <- r.
  - 011 ADD r <- a+b.
  - 100 SUB r <- a-b.
  - 111 HALT.
  - 101/110 illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore functions of state and ir_q; all strobes are 0 outside the states named below.
- Reset: state = IDLE, ir_q = 0, internal pc_cur = 0, latency counter = 0, illegal = 0. Every output is 0. Reset mid-instruction aborts without any further strobe.
- IDLE: start = 1 -> FETCH; otherwise hold.
- FETCH (1 cycle): ir_q <= instr_in; pc_cur <= pc_addr; -> DECODE.
- DECODE (1 cycle): pc_ld = 1, exactly one pulse per instruction, including HALT and illegal. Next state:
  - NOP -> FETCH.
  - LOAD -> MEM.
  - STORE/ADD/SUB -> EXEC.
  - HALT -> HALT.
  - Illegal -> HALT and illegal <= 1.
- EXEC (1 cycle):
  - ADD/SUB: rf_raddr_a = a, rf_raddr_b = b, alu_op per opcode, rf_waddr = r, rf_wsel = 0, rf_we = 1.
  - STORE: rf_raddr_a = r, dm_addr = addr, dm_we = 1.
- MEM: dm_addr held for exactly MEM_LAT cycles (counter counts 0..MEM_LAT-1), then -> WB.
- WB (1 cycle): rf_waddr = r, rf_wsel = 1, rf_we = 1, dm_addr still held.
- After EXEC, WB or NOP-DECODE:
  - HALT_ON_WRAP = 1 and pc_cur = 2**PC_W-1 -> HALT.
  - Otherwise -> FETCH; the PC wraps 7->0 naturally.
- Latency: NOP 2 cycles; ADD/SUB/STORE 3 cycles; LOAD 3+MEM_LAT cycles; HALT 2 cycles to halted = 1.
- HALT: absorbing; start ignored; only reset exits.
- start deassertion after leaving IDLE is ignored; execution continues to HALT.

Optional Feature:
- Macro FDC_STEP_MODE_EN.
- Defined: adds input port step (1 bit). The transition that would enter FETCH from a completed instruction instead enters PAUSE (busy = 0, no strobes). PAUSE + step = 1 -> FETCH. Executes one instruction per step. IDLE->FETCH on start is unchanged; reset -> IDLE.
- Undefined: no step port, no PAUSE state; execution is continuous.

Test Plan:
- ROM {ADD r1,r2,r3; HALT}, start pulse -> pc_ld high exactly at cycles 2 and 5; rf_we=1, rf_waddr=1, alu_op=0 at cycle 3; halted=1 at cycle 6, busy=0.
- LOAD r4,[0xA] with MEM_LAT=2 -> dm_addr=0xA for 3 cycles; single rf_we with rf_wsel=1, rf_waddr=4 on last; 5 cycles total.
- Opcode 101 at address 0 -> one pc_ld, then halted=1, illegal=1, no rf_we/dm_we ever asserted.
- 8 NOPs, HALT_ON_WRAP=0 -> pc_ld every 2 cycles, 9th fetch at pc_addr=0; HALT_ON_WRAP=1 -> halted=1 after 8th NOP.
- reset asserted during MEM of a LOAD -> all outputs 0 immediately; no rf_we; restart with start re-executes from IDLE.
- FDC_STEP_MODE_EN, 3 STOREs -> exactly one dm_we per step pulse; busy=0 between steps.
